// File: rtl/seq_detect_pkg.sv
// rtl/seq_detect_pkg.sv - shared state encoding and default pattern constants
package seq_detect_pkg;

  // Frame sequencer states
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int              DEF_PAT_W   = 5;
  localparam logic [4:0]      DEF_PATTERN = 5'b11011;

endpackage

// File: rtl/seq_detect_sched_matcher.sv
// rtl/seq_detect_sched_matcher.sv - overlapping serial pattern matcher with fill tracking
module pattern_matcher #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b11011
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic shift,
  input  logic din,
  output logic hit
);

  localparam int FILL_W = $clog2(PAT_W + 1);

  logic [PAT_W-1:0]  window_q, window_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PAT_W-1:0]  window_shifted;

  // Window as it will look after this cycle's bit; hit is judged on it so a
  // match on the final bit of a frame is reported in the same cycle.
  always_comb begin
    window_shifted = {window_q[PAT_W-2:0], din};
    hit            = shift && (fill_q >= FILL_W'(PAT_W - 1)) && (window_shifted == PATTERN);
  end

  // Next window/fill: clear wins over shift; fill saturates at PAT_W.
  always_comb begin
    window_d = window_q;
    fill_d   = fill_q;
    if (clr) begin
      window_d = '0;
      fill_d   = '0;
    end else if (shift) begin
      window_d = window_shifted;
      if (fill_q != FILL_W'(PAT_W)) begin
        fill_d = fill_q + FILL_W'(1);
      end
    end
  end

  // Window and fill registers
  always_ff @(posedge clk) begin
    if (reset) begin
      window_q <= '0;
      fill_q   <= '0;
    end else begin
      window_q <= window_d;
      fill_q   <= fill_d;
    end
  end

endmodule

// File: rtl/seq_detect_sched.sv
// rtl/seq_detect_sched.sv - round-robin scheduler sharing one pattern matcher across channels
module seq_detect_sched
  import seq_detect_pkg::*;
#(
  parameter int               NCH     = 4,
  parameter int               PAT_W   = DEF_PAT_W,
  parameter logic [PAT_W-1:0] PATTERN = DEF_PATTERN,
  parameter int               LEN_W   = 8,
  parameter int               CNT_W   = 8,
  localparam int              CH_W    = $clog2(NCH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [NCH-1:0]   req,
  input  logic [NCH-1:0]   bit_valid,
  input  logic [NCH-1:0]   bit_in,
  input  logic [LEN_W-1:0] frame_len,
  input  logic             abort,
  output logic [NCH-1:0]   gnt,
  output logic             busy,
  output logic             done,
  output logic [CH_W-1:0]  done_ch,
  output logic [CNT_W-1:0] match_cnt
);

  state_t           state_q, state_d;
  logic [NCH-1:0]   gnt_q, gnt_d;
  logic [CH_W-1:0]  gnt_idx_q, gnt_idx_d;
  logic [CH_W-1:0]  rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]  done_ch_q, done_ch_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic [LEN_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [CNT_W-1:0] match_cnt_q, match_cnt_d;

  logic             arb_found;
  logic [CH_W-1:0]  arb_pick;
  logic [CH_W-1:0]  arb_next_ptr;
  logic [CH_W:0]    arb_idx;
  logic [CH_W:0]    arb_inc;

  logic             m_clr;
  logic             m_shift;
  logic             m_din;
  logic             m_hit;
  logic [LEN_W-1:0] bit_cnt_inc;

  // Round-robin search: first requester at or above rr_ptr, wrapping mod NCH.
  always_comb begin
    arb_found    = 1'b0;
    arb_pick     = '0;
    arb_idx      = '0;
    arb_inc      = '0;
    arb_next_ptr = '0;
    for (int k = 0; k < NCH; k++) begin
      arb_idx = {1'b0, rr_ptr_q} + (CH_W+1)'(k);
      if (arb_idx >= (CH_W+1)'(NCH)) begin
        arb_idx = arb_idx - (CH_W+1)'(NCH);
      end
      if (!arb_found && req[arb_idx[CH_W-1:0]]) begin
        arb_found = 1'b1;
        arb_pick  = arb_idx[CH_W-1:0];
      end
    end
    arb_inc = {1'b0, arb_pick} + (CH_W+1)'(1);
    if (arb_inc == (CH_W+1)'(NCH)) begin
      arb_next_ptr = '0;
    end else begin
      arb_next_ptr = arb_inc[CH_W-1:0];
    end
  end

  // Frame sequencer: grant, bit consumption, hit counting, done/abort handling.
  always_comb begin
    state_d     = state_q;
    gnt_d       = gnt_q;
    gnt_idx_d   = gnt_idx_q;
    rr_ptr_d    = rr_ptr_q;
    done_ch_d   = done_ch_q;
    len_d       = len_q;
    bit_cnt_d   = bit_cnt_q;
    match_cnt_d = match_cnt_q;
    m_clr       = 1'b0;
    m_shift     = 1'b0;
    m_din       = bit_in[gnt_idx_q];
    bit_cnt_inc = bit_cnt_q + LEN_W'(1);

    case (state_q)
      IDLE: begin
        if (arb_found) begin
          m_clr       = 1'b1;
          len_d       = frame_len;
          bit_cnt_d   = '0;
          match_cnt_d = '0;
          rr_ptr_d    = arb_next_ptr;
          gnt_idx_d   = arb_pick;
          if (frame_len == '0) begin
            // Empty frame: report immediately, never assert gnt.
            state_d   = DONE;
            done_ch_d = arb_pick;
            gnt_d     = '0;
          end else begin
            state_d = RUN;
            gnt_d   = {{(NCH-1){1'b0}}, 1'b1} << arb_pick;
          end
        end
      end

      RUN: begin
        if (abort) begin
          // Abort beats a coincident last bit; the bit is not consumed.
          state_d = IDLE;
          gnt_d   = '0;
        end else if (bit_valid[gnt_idx_q]) begin
          m_shift   = 1'b1;
          bit_cnt_d = bit_cnt_inc;
          if (m_hit && (match_cnt_q != {CNT_W{1'b1}})) begin
            match_cnt_d = match_cnt_q + CNT_W'(1);
          end
          if (bit_cnt_inc == len_q) begin
            state_d   = DONE;
            gnt_d     = '0;
            done_ch_d = gnt_idx_q;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= IDLE;
      gnt_q       <= '0;
      gnt_idx_q   <= '0;
      rr_ptr_q    <= '0;
      done_ch_q   <= '0;
      len_q       <= '0;
      bit_cnt_q   <= '0;
      match_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      gnt_q       <= gnt_d;
      gnt_idx_q   <= gnt_idx_d;
      rr_ptr_q    <= rr_ptr_d;
      done_ch_q   <= done_ch_d;
      len_q       <= len_d;
      bit_cnt_q   <= bit_cnt_d;
      match_cnt_q <= match_cnt_d;
    end
  end

  pattern_matcher #(
    .PAT_W   (PAT_W),
    .PATTERN (PATTERN)
  ) u_matcher (
    .clk   (clk),
    .reset (reset),
    .clr   (m_clr),
    .shift (m_shift),
    .din   (m_din),
    .hit   (m_hit)
  );

  assign gnt       = gnt_q;
  assign busy      = (state_q == RUN);
  assign done      = (state_q == DONE);
  assign done_ch   = done_ch_q;
  assign match_cnt = match_cnt_q;

endmodule

// File: tb/tb_seq_detect_sched.sv
// tb/tb_seq_detect_sched.sv - directed self-checking bench for seq_detect_sched
module tb_seq_detect_sched;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [3:0] bit_valid;
  logic [3:0] bit_in;
  logic [7:0] frame_len;
  logic       abort;

  logic [3:0] gnt, gnt_s;
  logic       busy, busy_s;
  logic       done, done_s;
  logic [1:0] done_ch, done_ch_s;
  logic [7:0] match_cnt;
  logic [1:0] match_cnt_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  seq_detect_sched dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .frame_len (frame_len),
    .abort     (abort),
    .gnt       (gnt),
    .busy      (busy),
    .done      (done),
    .done_ch   (done_ch),
    .match_cnt (match_cnt)
  );

  seq_detect_sched #(.CNT_W(2)) dut_sat (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .bit_valid (bit_valid),
    .bit_in    (bit_in),
    .frame_len (frame_len),
    .abort     (abort),
    .gnt       (gnt_s),
    .busy      (busy_s),
    .done      (done_s),
    .done_ch   (done_ch_s),
    .match_cnt (match_cnt_s)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [7:0]  p8;
    logic [4:0]  p5;
    logic [5:0]  p6;
    logic [13:0] p14;

    p8  = 8'b11011011;
    p5  = 5'b11011;
    p6  = 6'b011011;
    p14 = 14'b11011011011011;

    reset = 1'b1; req = '0; bit_valid = '0; bit_in = '0; frame_len = '0; abort = 1'b0;
    tick();
    tick();
    check("rst_gnt", gnt, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_done_ch", done_ch, 0);
    check("rst_match_cnt", match_cnt, 0);
    reset = 1'b0;

    // 1: single channel, overlapping hits
    req = 4'b0001; frame_len = 8'd8;
    tick();
    check("t1_gnt", gnt, 4'b0001);
    check("t1_busy", busy, 1);
    req = '0;
    for (int i = 0; i < 8; i++) begin
      bit_valid = 4'b0001;
      bit_in    = {4{p8[7-i]}};
      tick();
      if (i < 7) check("t1_gnt_hold", gnt, 4'b0001);
    end
    bit_valid = '0;
    check("t1_done", done, 1);
    check("t1_done_ch", done_ch, 0);
    check("t1_match_cnt", match_cnt, 2);
    check("t1_gnt_drop", gnt, 0);
    check("t1_busy_drop", busy, 0);
    tick();
    check("t1_done_pulse", done, 0);

    // 2: all channels requesting, round-robin order from rr_ptr=0
    reset = 1'b1;
    tick();
    reset = 1'b0;
    req = 4'b1111; frame_len = 8'd5;
    for (int f = 0; f < 5; f++) begin
      tick();
      check("t2_gnt", gnt, 4'b0001 << (f % 4));
      for (int b = 0; b < 5; b++) begin
        bit_valid = 4'b1111;
        bit_in    = {4{p5[4-b]}};
        tick();
      end
      bit_valid = '0;
      check("t2_done", done, 1);
      check("t2_done_ch", done_ch, f % 4);
      check("t2_match_cnt", match_cnt, 1);
      tick();
    end
    req = '0;

    // 3: gapped strobes on ch2, noise on other channels (rr_ptr=1)
    req = 4'b0100; frame_len = 8'd6;
    tick();
    check("t3_gnt", gnt, 4'b0100);
    req = '0;
    for (int b = 0; b < 6; b++) begin
      for (int g = 0; g < 2; g++) begin
        bit_valid = 4'b1011;
        bit_in    = 4'b1011;
        tick();
      end
      bit_valid = 4'b1111;
      bit_in    = {1'b1, p6[5-b], 1'b1, 1'b1};
      tick();
      if (b == 4) begin
        check("t3_not_done_early", done, 0);
        check("t3_busy", busy, 1);
      end
    end
    bit_valid = '0;
    check("t3_done", done, 1);
    check("t3_done_ch", done_ch, 2);
    check("t3_match_cnt", match_cnt, 1);
    tick();

    // 4: zero-length frame on ch1 (rr_ptr=3)
    req = 4'b0010; frame_len = 8'd0;
    tick();
    check("t4_done", done, 1);
    check("t4_done_ch", done_ch, 1);
    check("t4_match_cnt", match_cnt, 0);
    check("t4_gnt", gnt, 0);
    check("t4_busy", busy, 0);
    req = '0;
    tick();
    check("t4_done_pulse", done, 0);

    // 5: abort mid-frame on ch0 (rr_ptr=2)
    req = 4'b0001; frame_len = 8'd8;
    tick();
    check("t5_gnt", gnt, 4'b0001);
    req = '0;
    for (int b = 0; b < 4; b++) begin
      bit_valid = 4'b0001;
      bit_in    = {4{p8[7-b]}};
      tick();
    end
    bit_valid = '0;
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("t5_abort_gnt", gnt, 0);
    check("t5_abort_busy", busy, 0);
    check("t5_abort_done", done, 0);
    tick();
    check("t5_no_late_done", done, 0);
    req = 4'b0011;
    tick();
    check("t5_rr_gnt", gnt, 4'b0010);
    req = '0;
    abort = 1'b1;
    tick();
    check("t5_abort2_busy", busy, 0);
    // abort held through IDLE and DONE does not suppress the pulse (rr_ptr=2)
    req = 4'b0100; frame_len = 8'd0;
    tick();
    check("t5_abort_idle_done", done, 1);
    check("t5_abort_idle_done_ch", done_ch, 2);
    req = '0;
    tick();
    abort = 1'b0;
    check("t5_abort_done_end", done, 0);

    // 6a: reset coincident with the hit-producing last bit (rr_ptr=3)
    req = 4'b0001; frame_len = 8'd5;
    tick();
    check("t6_gnt", gnt, 4'b0001);
    req = '0;
    for (int b = 0; b < 4; b++) begin
      bit_valid = 4'b0001;
      bit_in    = {4{p5[4-b]}};
      tick();
    end
    bit_valid = 4'b0001;
    bit_in    = {4{p5[0]}};
    reset = 1'b1;
    tick();
    reset = 1'b0;
    bit_valid = '0;
    check("t6_rst_done", done, 0);
    check("t6_rst_gnt", gnt, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_done_ch", done_ch, 0);
    check("t6_rst_match_cnt", match_cnt, 0);
    tick();
    check("t6_rst_no_done", done, 0);

    // 6b: four overlapping hits; rr_ptr back at 0 after reset
    req = 4'b0011; frame_len = 8'd14;
    tick();
    check("t6_rr_reset_gnt", gnt, 4'b0001);
    req = '0;
    for (int b = 0; b < 14; b++) begin
      bit_valid = 4'b1111;
      bit_in    = {4{p14[13-b]}};
      tick();
    end
    bit_valid = '0;
    check("t6_done", done, 1);
    check("t6_done_ch", done_ch, 0);
    check("t6_match_cnt", match_cnt, 4);
    check("t6_sat_match_cnt", match_cnt_s, 3);
    tick();
    check("t6_match_cnt_stable", match_cnt, 4);
    check("t6_sat_stable", match_cnt_s, 3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
